// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read/write pointer blocks.
// Holds the pointer sizing helper, the output-register state encoding and the modular occupancy helper.
package fifo_pkg;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Occupancy is the pointer difference taken modulo 2^pw, so the wrap bit resolves full vs empty.
  function automatic logic [31:0] ptr_occ(input logic [31:0] w, input logic [31:0] r, input int pw);
    logic [31:0] mask;
    mask = (32'd1 << pw) - 32'd1;
    return (w - r) & mask;
  endfunction

endpackage

// File: rtl/fifo_out_reg.sv
// One-entry valid/ready output register that prefetches the FIFO head entry.
// Reports o_fetch whenever it loads, which is what advances the read pointer.
module fifo_out_reg
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_avail,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_rdy,
  output logic             o_val,
  output logic [WIDTH-1:0] o_msg,
  output logic             o_fetch
);

  out_state_e       r_state;
  out_state_e       w_state_nxt;
  logic             w_load;
  logic [WIDTH-1:0] r_msg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= OUT_EMPTY;
      r_msg   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) r_msg <= i_data;
    end
  end

  // A pop with nothing behind it drops to OUT_EMPTY and leaves r_msg stale.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      OUT_EMPTY: begin
        if (i_avail) begin
          w_load      = 1'b1;
          w_state_nxt = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (i_rdy) begin
          if (i_avail) w_load      = 1'b1;
          else         w_state_nxt = OUT_EMPTY;
        end
      end
      default: w_state_nxt = OUT_EMPTY;
    endcase
  end

  assign o_val   = (r_state == OUT_FULL);
  assign o_msg   = r_msg;
  assign o_fetch = w_load;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side FIFO controller: owns the read pointer and empty flag, and prefetches
// the head entry into a valid/ready output register for the PE/accumulator stages.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = ptr_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PTR_WIDTH-1:0] w_ptr,
  output logic [PTR_WIDTH-1:0] r_ptr,
  output logic                 empty,
  output logic [PTR_WIDTH-2:0] rd_addr,
  input  logic [WIDTH-1:0]     rd_data,
  output logic                 deq_val,
  input  logic                 deq_rdy,
  output logic [WIDTH-1:0]     deq_msg,
  output logic [PTR_WIDTH-1:0] count
);

  logic                 w_fetch;
  logic [PTR_WIDTH-1:0] w_occ;

  assign empty   = (r_ptr == w_ptr);
  assign rd_addr = r_ptr[PTR_WIDTH-2:0];
  assign w_occ   = PTR_WIDTH'(ptr_occ(32'(w_ptr), 32'(r_ptr), PTR_WIDTH));
  // Peaks at DEPTH+1, which the extra wrap bit of PTR_WIDTH accommodates.
  assign count   = w_occ + PTR_WIDTH'(deq_val);

  fifo_out_reg #(.WIDTH(WIDTH)) u_out (
    .clk     (clk),
    .rst     (rst),
    .i_avail (~empty),
    .i_data  (rd_data),
    .i_rdy   (deq_rdy),
    .o_val   (deq_val),
    .o_msg   (deq_msg),
    .o_fetch (w_fetch)
  );

  // The array slot frees at fetch, so the write side sees it one cycle after the fetch edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_ptr <= '0;
    else if (w_fetch) r_ptr <= r_ptr + 1'b1;
  end

endmodule
